// File: rtl/imem_arbiter_if.sv
// Bundle of the two fetch-client ports and the ROM pins shared by the instruction-memory arbiter.
// The arbiter takes the slave side; the fetch clients (and the ROM) take the master side.
interface imem_arbiter_if;
    logic        r0_req;
    logic        r0_lock;
    logic [63:0] r0_addr;
    logic        r0_gnt;
    logic        r0_rvalid;
    logic [31:0] r0_rdata;
    logic        r0_err;

    logic        r1_req;
    logic        r1_lock;
    logic [63:0] r1_addr;
    logic        r1_gnt;
    logic        r1_rvalid;
    logic [31:0] r1_rdata;
    logic        r1_err;

    logic [63:0] mem_address;
    logic [31:0] mem_instruction;

    modport slave (
        input  r0_req, r0_lock, r0_addr,
        output r0_gnt, r0_rvalid, r0_rdata, r0_err,
        input  r1_req, r1_lock, r1_addr,
        output r1_gnt, r1_rvalid, r1_rdata, r1_err,
        output mem_address,
        input  mem_instruction
    );

    modport master (
        output r0_req, r0_lock, r0_addr,
        input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
        output r1_req, r1_lock, r1_addr,
        input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
        input  mem_address,
        output mem_instruction
    );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one combinational instruction ROM between CPU fetch (port 0)
// and crypto-engine fetch (port 1), with bounded burst locking and registered responses.
module imem_arbiter #(
    parameter int MEM_SIZE  = 4096,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    imem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    localparam int          CW        = $clog2(MAX_BURST + 1);
    localparam logic [63:0] LAST_WORD = 64'(MEM_SIZE - 4);

    // Full 64-bit compare so addresses near 2^64 never wrap into range.
    function automatic logic f_addr_err(input logic [63:0] addr);
        return (addr[1:0] != 2'b00) || (addr > LAST_WORD);
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_rr_ptr;
    logic          w_rr_nxt;
    logic [CW-1:0] r_burst_cnt;
    logic [CW-1:0] w_burst_nxt;

    logic [1:0]    w_req;
    logic [1:0]    w_lock;
    logic          w_pref;
    logic          w_hold;
    logic          w_any;
    logic          w_sel;
    logic          w_gnt0;
    logic          w_gnt1;

    logic          r0_rvalid_r;
    logic [31:0]   r0_rdata_r;
    logic          r0_err_r;
    logic          r1_rvalid_r;
    logic [31:0]   r1_rdata_r;
    logic          r1_err_r;

    assign w_req  = {bus.r1_req,  bus.r0_req};
    assign w_lock = {bus.r1_lock, bus.r0_lock};

    // FSM state, round-robin pointer and burst counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ARB;
            r_rr_ptr    <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Grant decision and next state; a lock owner keeps the ROM until it drops lock or hits MAX_BURST.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_burst_nxt = r_burst_cnt;
        w_pref      = r_rr_ptr;
        w_hold      = 1'b0;
        w_any       = 1'b0;
        w_sel       = 1'b0;
        case (r_state)
            ST_ARB: begin
                w_pref = r_rr_ptr;
            end
            ST_LOCK0: begin
                w_pref = 1'b1;
                w_hold = w_req[0] && w_lock[0] && (r_burst_cnt < CW'(MAX_BURST));
            end
            ST_LOCK1: begin
                w_pref = 1'b0;
                w_hold = w_req[1] && w_lock[1] && (r_burst_cnt < CW'(MAX_BURST));
            end
            default: begin
                w_pref = r_rr_ptr;
            end
        endcase

        if (w_hold) begin
            w_any       = 1'b1;
            w_sel       = (r_state == ST_LOCK1);
            w_burst_nxt = r_burst_cnt + CW'(1);
        end else begin
            if (w_req[w_pref]) begin
                w_any = 1'b1;
                w_sel = w_pref;
            end else if (w_req[~w_pref]) begin
                w_any = 1'b1;
                w_sel = ~w_pref;
            end else begin
                w_any = 1'b0;
            end

            if (w_any) begin
                w_rr_nxt = ~w_sel;
                if (w_lock[w_sel]) begin
                    w_state_nxt = w_sel ? ST_LOCK1 : ST_LOCK0;
                    w_burst_nxt = CW'(1);
                end else begin
                    w_state_nxt = ST_ARB;
                    w_burst_nxt = '0;
                end
            end else begin
                w_state_nxt = ST_ARB;
                w_burst_nxt = '0;
            end
        end
    end

    // Grant strobes and ROM address; forced quiet while reset is asserted.
    always_comb begin
        w_gnt0          = 1'b0;
        w_gnt1          = 1'b0;
        bus.mem_address = 64'h0;
        if (reset) begin
            w_gnt0          = 1'b0;
            w_gnt1          = 1'b0;
            bus.mem_address = 64'h0;
        end else if (w_any) begin
            if (w_sel) begin
                w_gnt1          = 1'b1;
                bus.mem_address = bus.r1_addr;
            end else begin
                w_gnt0          = 1'b1;
                bus.mem_address = bus.r0_addr;
            end
        end else begin
            bus.mem_address = 64'h0;
        end
    end

    assign bus.r0_gnt = w_gnt0;
    assign bus.r1_gnt = w_gnt1;

    // Response registers: capture the ROM word (or an error) one cycle after the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r0_rvalid_r <= 1'b0;
            r0_rdata_r  <= 32'h0;
            r0_err_r    <= 1'b0;
            r1_rvalid_r <= 1'b0;
            r1_rdata_r  <= 32'h0;
            r1_err_r    <= 1'b0;
        end else begin
            r0_rvalid_r <= w_gnt0;
            r1_rvalid_r <= w_gnt1;
            if (w_gnt0) begin
                r0_err_r   <= f_addr_err(bus.r0_addr);
                r0_rdata_r <= f_addr_err(bus.r0_addr) ? 32'h0 : bus.mem_instruction;
            end else begin
                r0_err_r   <= r0_err_r;
                r0_rdata_r <= r0_rdata_r;
            end
            if (w_gnt1) begin
                r1_err_r   <= f_addr_err(bus.r1_addr);
                r1_rdata_r <= f_addr_err(bus.r1_addr) ? 32'h0 : bus.mem_instruction;
            end else begin
                r1_err_r   <= r1_err_r;
                r1_rdata_r <= r1_rdata_r;
            end
        end
    end

    assign bus.r0_rvalid = r0_rvalid_r;
    assign bus.r0_rdata  = r0_rdata_r;
    assign bus.r0_err    = r0_err_r;
    assign bus.r1_rvalid = r1_rvalid_r;
    assign bus.r1_rdata  = r1_rdata_r;
    assign bus.r1_err    = r1_err_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter, checked against a behavioural arbitration model.
module tb_imem_arbiter;

    localparam int MEM_SIZE  = 4096;
    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_arbiter_if bus ();

    imem_arbiter #(.MEM_SIZE(MEM_SIZE), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] rom [0:1023];
    assign bus.mem_instruction = rom[bus.mem_address[11:2]];

    int n_total = 0;
    int n_bad   = 0;

    // stimulus copies and model state
    logic        q  [2];
    logic        lk [2];
    logic [63:0] ad [2];
    int          m_owner;
    int          m_run;
    int          m_favour;
    logic        exp_valid [2];
    logic [31:0] exp_data  [2];
    logic        exp_err   [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic q0, input logic l0, input logic [63:0] a0,
                         input logic q1, input logic l1, input logic [63:0] a1);
        q[0] = q0; lk[0] = l0; ad[0] = a0;
        q[1] = q1; lk[1] = l1; ad[1] = a1;
        bus.r0_req = q0; bus.r0_lock = l0; bus.r0_addr = a0;
        bus.r1_req = q1; bus.r1_lock = l1; bus.r1_addr = a1;
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_run    = 0;
        m_favour = 0;
        for (int p = 0; p < 2; p++) begin
            exp_valid[p] = 1'b0;
            exp_data[p]  = 32'h0;
            exp_err[p]   = 1'b0;
        end
    endtask

    // One clock: check grants for the driven inputs, advance the model, check responses after the edge.
    task automatic cycle(output int g, output int dut_g);
        int  pref;
        logic e;
        #1;
        g = -1;
        if (m_owner >= 0 && q[m_owner] && lk[m_owner] && m_run < MAX_BURST) begin
            g = m_owner;
            m_run++;
        end else begin
            pref = (m_owner >= 0) ? 1 - m_owner : m_favour;
            if (q[pref]) g = pref;
            else if (q[1 - pref]) g = 1 - pref;
            if (g >= 0) begin
                m_favour = 1 - g;
                if (lk[g]) begin m_owner = g; m_run = 1; end
                else begin m_owner = -1; m_run = 0; end
            end else begin
                m_owner = -1;
                m_run   = 0;
            end
        end
        dut_g = bus.r0_gnt ? 0 : (bus.r1_gnt ? 1 : -1);
        chk("gnt0", bus.r0_gnt, g == 0);
        chk("gnt1", bus.r1_gnt, g == 1);
        chk("mem_address", bus.mem_address, (g < 0) ? 64'h0 : ad[g]);
        for (int p = 0; p < 2; p++) begin
            exp_valid[p] = (g == p);
            if (g == p) begin
                e = (ad[p][1:0] != 2'b00) || (ad[p] > 64'(MEM_SIZE - 4));
                exp_err[p]  = e;
                exp_data[p] = e ? 32'h0 : rom[ad[p][11:2]];
            end
        end
        @(posedge clk);
        #1;
        chk("rvalid0", bus.r0_rvalid, exp_valid[0]);
        chk("rdata0",  bus.r0_rdata,  exp_data[0]);
        chk("err0",    bus.r0_err,    exp_err[0]);
        chk("rvalid1", bus.r1_rvalid, exp_valid[1]);
        chk("rdata1",  bus.r1_rdata,  exp_data[1]);
        chk("err1",    bus.r1_err,    exp_err[1]);
    endtask

    function automatic logic [63:0] gen_addr();
        logic [63:0] a;
        case ($urandom_range(0, 9))
            0:       a = {32'h0, $urandom} | 64'h1;
            1:       a = 64'(MEM_SIZE - 4);
            2:       a = 64'(MEM_SIZE);
            3:       a = 64'hFFFF_FFFF_FFFF_FFFC;
            4:       a = {$urandom, $urandom} & ~64'h3;
            default: a = 64'($urandom_range(0, 1023)) << 2;
        endcase
        return a;
    endfunction

    initial begin
        int g, dg, prev_dg, n0, n1, run1, max_run1, ncyc;
        logic        nq  [2];
        logic        nl  [2];
        logic [63:0] na  [2];
        logic        exp4 [4];
        logic [63:0] a4   [4];

        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        reset = 1'b1;
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt0", bus.r0_gnt, 1'b0);
        chk("rst_gnt1", bus.r1_gnt, 1'b0);
        chk("rst_rvalid0", bus.r0_rvalid, 1'b0);
        chk("rst_rvalid1", bus.r1_rvalid, 1'b0);
        chk("rst_addr", bus.mem_address, 64'h0);
        reset = 1'b0;

        // randomized phase with request hold rule
        for (int p = 0; p < 2; p++) begin nq[p] = 1'b0; nl[p] = 1'b0; na[p] = 64'h0; end
        for (int i = 0; i < 500; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(nq[p] && i > 0 && g != p)) begin
                    nq[p] = ($urandom_range(0, 99) < 65);
                    nl[p] = ($urandom_range(0, 3) != 0);
                    na[p] = gen_addr();
                end
            end
            drive(nq[0], nl[0], na[0], nq[1], nl[1], na[1]);
            cycle(g, dg);
        end

        // contention: grants must alternate
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        cycle(g, dg);
        drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h100);
        cycle(g, prev_dg);
        for (int i = 0; i < 6; i++) begin
            cycle(g, dg);
            chk("t2_alternate", dg, 64'(1 - prev_dg));
            prev_dg = dg;
        end

        // lock burst bounded by MAX_BURST
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        cycle(g, dg);
        n1 = 0; run1 = 0; max_run1 = 0;
        for (int i = 0; i < 60 && n1 < 12; i++) begin
            drive(1'b1, 1'b0, 64'h20, 1'b1, 1'b1, 64'h100 + 64'(4 * n1));
            cycle(g, dg);
            if (dg == 1) begin n1++; run1++; end
            else run1 = 0;
            if (run1 > max_run1) max_run1 = run1;
        end
        chk("t3_r1_grants", n1, 12);
        chk("t3_max_run", max_run1, MAX_BURST);

        // alignment / bounds errors
        a4[0] = 64'h2;               exp4[0] = 1'b1;
        a4[1] = 64'(MEM_SIZE - 4);   exp4[1] = 1'b0;
        a4[2] = 64'(MEM_SIZE);       exp4[2] = 1'b1;
        a4[3] = 64'hFFFF_FFFF_FFFF_FFFC; exp4[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, a4[k], 1'b0, 1'b0, 64'h0);
            cycle(g, dg);
            chk("t4_err", bus.r0_err, exp4[k]);
            drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
            cycle(g, dg);
        end
        chk("t4_rdata_last", bus.r0_rdata, 32'h0);

        // lock release after lock drops on 4th grant
        n0 = 0; ncyc = 0;
        for (int i = 0; i < 20 && n0 < 4; i++) begin
            drive(1'b1, (n0 < 3), 64'h40 + 64'(4 * n0), 1'b0, 1'b0, 64'h0);
            cycle(g, dg);
            ncyc++;
            if (dg == 0) n0++;
        end
        chk("t5_cycles", ncyc, 4);
        drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h200);
        cycle(g, dg);
        chk("t5_r1_next", dg, 64'(1));

        // reset asserted mid-transfer
        drive(1'b1, 1'b0, 64'h40, 1'b0, 1'b0, 64'h0);
        cycle(g, dg);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_rvalid0", bus.r0_rvalid, 1'b0);
        chk("rst_mid_rdata0", bus.r0_rdata, 32'h0);
        chk("rst_mid_gnt0", bus.r0_gnt, 1'b0);
        chk("rst_mid_addr", bus.mem_address, 64'h0);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 64'h10, 1'b0, 1'b0, 64'h0);
        cycle(g, dg);
        chk("t1_gnt_seen", dg, 64'(0));
        chk("t1_rvalid", bus.r0_rvalid, 1'b1);
        chk("t1_rdata", bus.r0_rdata, rom[4]);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        cycle(g, dg);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
